// File: rtl/rptr_sync_wlevel.sv
// Write-side read-pointer synchronizer with occupancy level, freed-word count,
// almost-full watermark (with hysteresis) and sticky pointer-consistency error.
module rptr_sync_wlevel #(
    parameter int unsigned ADDR_SIZE    = 4,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned AFULL_THRESH = 12,
    parameter int unsigned AFULL_HYST   = 2
) (
    input  logic                 wr_clk,
    input  logic                 wr_rstn,
    input  logic [ADDR_SIZE:0]   rd_ptr_gray,
    input  logic [ADDR_SIZE:0]   wptr_bin,
    input  logic                 err_clr,
    output logic [ADDR_SIZE:0]   rd_ptr_gray_sync,
    output logic [ADDR_SIZE:0]   rd_ptr_bin_sync,
    output logic [ADDR_SIZE:0]   wr_level,
    output logic [ADDR_SIZE:0]   words_freed,
    output logic                 almost_full,
    output logic                 ptr_err
);

    localparam int unsigned PW        = ADDR_SIZE + 1;
    localparam int unsigned DEPTH     = 1 << ADDR_SIZE;
    localparam int unsigned AF_CLR_LT = AFULL_THRESH - AFULL_HYST;

    typedef enum logic {
        AF_CLEAR = 1'b0,
        AF_SET   = 1'b1
    } af_state_e;

    logic [PW-1:0] sync_q [SYNC_STAGES];
    logic [PW-1:0] rd_bin_q;
    logic [PW-1:0] rd_bin_d;
    logic [PW-1:0] wr_level_q;
    logic [PW-1:0] level_d;
    logic [PW-1:0] words_freed_q;
    logic [PW-1:0] words_freed_d;
    logic          err_set_c;
    logic          ptr_err_q;
    af_state_e     af_state_q;

    // Plain flop chain for the asynchronous Gray pointer; no logic between stages.
    always_ff @(posedge wr_clk or negedge wr_rstn) begin
        if (!wr_rstn) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= rd_ptr_gray;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Gray-to-binary of the last stage, occupancy and freed-word arithmetic (modulo 2^PW).
    always_comb begin
        rd_bin_d = '0;
        rd_bin_d[PW-1] = sync_q[SYNC_STAGES-1][PW-1];
        for (int i = int'(PW) - 2; i >= 0; i--) begin
            rd_bin_d[i] = rd_bin_d[i+1] ^ sync_q[SYNC_STAGES-1][i];
        end
        level_d       = wptr_bin - rd_bin_q;
        words_freed_d = rd_bin_d - rd_bin_q;
        err_set_c     = (level_d > PW'(DEPTH)) || (words_freed_d > PW'(DEPTH));
    end

    // Registered binary pointer, level and freed count.
    always_ff @(posedge wr_clk or negedge wr_rstn) begin
        if (!wr_rstn) begin
            rd_bin_q      <= '0;
            wr_level_q    <= '0;
            words_freed_q <= '0;
        end else begin
            rd_bin_q      <= rd_bin_d;
            wr_level_q    <= level_d;
            words_freed_q <= words_freed_d;
        end
    end

    // Almost-full watermark: set at threshold, clear only below threshold minus hysteresis.
    always_ff @(posedge wr_clk or negedge wr_rstn) begin
        if (!wr_rstn) begin
            af_state_q <= AF_CLEAR;
        end else begin
            case (af_state_q)
                AF_CLEAR: if (level_d >= PW'(AFULL_THRESH)) af_state_q <= AF_SET;
                AF_SET:   if (level_d <  PW'(AF_CLR_LT))    af_state_q <= AF_CLEAR;
                default:  af_state_q <= AF_CLEAR;
            endcase
        end
    end

    // Sticky error; a new set takes priority over a clear in the same cycle.
    always_ff @(posedge wr_clk or negedge wr_rstn) begin
        if (!wr_rstn) begin
            ptr_err_q <= 1'b0;
        end else if (err_set_c) begin
            ptr_err_q <= 1'b1;
        end else if (err_clr) begin
            ptr_err_q <= 1'b0;
        end
    end

    assign rd_ptr_gray_sync = sync_q[SYNC_STAGES-1];
    assign rd_ptr_bin_sync  = rd_bin_q;
    assign wr_level         = wr_level_q;
    assign words_freed      = words_freed_q;
    assign almost_full      = (af_state_q == AF_SET);
    assign ptr_err          = ptr_err_q;

endmodule

// File: tb/tb_rptr_sync_wlevel.sv
// Directed bench for rptr_sync_wlevel (defaults: ADDR_SIZE 4, SYNC_STAGES 2, thresh 12, hyst 2).
module tb_rptr_sync_wlevel;

    localparam int S = 2;

    logic       wr_clk = 1'b0;
    logic       wr_rstn = 1'b1;
    logic [4:0] rd_ptr_gray = '0;
    logic [4:0] wptr_bin = '0;
    logic       err_clr = 1'b0;
    logic [4:0] rd_ptr_gray_sync;
    logic [4:0] rd_ptr_bin_sync;
    logic [4:0] wr_level;
    logic [4:0] words_freed;
    logic       almost_full;
    logic       ptr_err;

    int total  = 0;
    int passed = 0;

    rptr_sync_wlevel #(
        .ADDR_SIZE(4), .SYNC_STAGES(S), .AFULL_THRESH(12), .AFULL_HYST(2)
    ) dut (
        .wr_clk           (wr_clk),
        .wr_rstn          (wr_rstn),
        .rd_ptr_gray      (rd_ptr_gray),
        .wptr_bin         (wptr_bin),
        .err_clr          (err_clr),
        .rd_ptr_gray_sync (rd_ptr_gray_sync),
        .rd_ptr_bin_sync  (rd_ptr_bin_sync),
        .wr_level         (wr_level),
        .words_freed      (words_freed),
        .almost_full      (almost_full),
        .ptr_err          (ptr_err)
    );

    always #5 wr_clk = ~wr_clk;

    typedef struct {
        logic [4:0] wptr;
        logic [4:0] rgray;
        logic       clr;
        logic [4:0] exp_level;
        logic       exp_af;
        logic       exp_err;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge wr_clk);
            #1;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " gray_sync"},   32'(rd_ptr_gray_sync), 0);
        check({tag, " bin_sync"},    32'(rd_ptr_bin_sync), 0);
        check({tag, " wr_level"},    32'(wr_level), 0);
        check({tag, " words_freed"}, 32'(words_freed), 0);
        check({tag, " almost_full"}, 32'(almost_full), 0);
        check({tag, " ptr_err"},     32'(ptr_err), 0);
    endtask

    vec_t vecs [9];

    initial begin
        // Wrap, full-level, sticky-error and freed-count-overflow vectors (applied in order).
        vecs[0] = '{5'd18, 5'b00100, 1'b0, 5'd11, 1'b0, 1'b0}; // rptr 7
        vecs[1] = '{5'd18, 5'b11011, 1'b0, 5'd0,  1'b0, 1'b0}; // rptr 18
        vecs[2] = '{5'd2,  5'b11011, 1'b0, 5'd16, 1'b1, 1'b0}; // legal full across wrap
        vecs[3] = '{5'd3,  5'b11011, 1'b0, 5'd17, 1'b1, 1'b1}; // over-full -> error
        vecs[4] = '{5'd3,  5'b11011, 1'b1, 5'd17, 1'b1, 1'b1}; // clear while still bad
        vecs[5] = '{5'd2,  5'b11011, 1'b0, 5'd16, 1'b1, 1'b1}; // condition gone, sticky
        vecs[6] = '{5'd2,  5'b11011, 1'b1, 5'd16, 1'b1, 1'b0}; // clear takes effect
        vecs[7] = '{5'd20, 5'b11011, 1'b0, 5'd2,  1'b0, 1'b0}; // level 2, af clears
        vecs[8] = '{5'd20, 5'b01100, 1'b0, 5'd12, 1'b1, 1'b1}; // rptr 18->8: freed 22

        // Asynchronous reset with no clock edge
        #1;
        rd_ptr_gray = 5'b10101;
        wptr_bin    = 5'd7;
        wr_rstn     = 1'b0;
        #1;
        check_all_zero("reset");

        rd_ptr_gray = '0;
        wptr_bin    = '0;
        tick(2);
        wr_rstn = 1'b1;

        // Write pointer ramp: level follows with one-cycle lag, af rises at 12
        for (int w = 0; w <= 12; w++) begin
            wptr_bin = 5'(w);
            tick(1);
            check($sformatf("ramp level w=%0d", w), 32'(wr_level), 32'(w));
            check($sformatf("ramp af w=%0d", w), 32'(almost_full), (w >= 12) ? 1 : 0);
        end

        // Hysteresis and synchronizer latency
        rd_ptr_gray = 5'b00001;
        tick(S - 1);
        check("lat gray_sync early", 32'(rd_ptr_gray_sync), 0);
        tick(1);
        check("lat gray_sync", 32'(rd_ptr_gray_sync), 1);
        check("lat bin_sync early", 32'(rd_ptr_bin_sync), 0);
        tick(1);
        check("lat bin_sync", 32'(rd_ptr_bin_sync), 1);
        check("lat words_freed", 32'(words_freed), 1);
        check("lat level early", 32'(wr_level), 12);
        tick(1);
        check("hyst level 11", 32'(wr_level), 11);
        check("hyst af 11", 32'(almost_full), 1);
        check("hyst words_freed back", 32'(words_freed), 0);
        rd_ptr_gray = 5'b00011;
        tick(S + 2);
        check("hyst level 10", 32'(wr_level), 10);
        check("hyst af 10", 32'(almost_full), 1);
        rd_ptr_gray = 5'b00010;
        tick(S + 1);
        check("hyst level pre 9", 32'(wr_level), 10);
        check("hyst af pre 9", 32'(almost_full), 1);
        tick(1);
        check("hyst level 9", 32'(wr_level), 9);
        check("hyst af 9", 32'(almost_full), 0);

        // Fast reader: Gray(4) then Gray(7) between two edges
        rd_ptr_gray = 5'b00110;
        tick(S + 3);
        check("fast level 8", 32'(wr_level), 8);
        rd_ptr_gray = 5'b00100;
        tick(S + 1);
        check("fast words_freed 3", 32'(words_freed), 3);
        tick(1);
        check("fast words_freed 0", 32'(words_freed), 0);
        check("fast level 5", 32'(wr_level), 5);
        check("fast ptr_err", 32'(ptr_err), 0);

        // Table-driven wrap / error vectors
        for (int i = 0; i < 9; i++) begin
            wptr_bin    = vecs[i].wptr;
            rd_ptr_gray = vecs[i].rgray;
            err_clr     = vecs[i].clr;
            tick(1);
            err_clr     = 1'b0;
            tick(S + 2);
            check($sformatf("vec%0d level", i), 32'(wr_level), 32'(vecs[i].exp_level));
            check($sformatf("vec%0d af", i), 32'(almost_full), 32'(vecs[i].exp_af));
            check($sformatf("vec%0d err", i), 32'(ptr_err), 32'(vecs[i].exp_err));
        end

        // Clear after the freed-count error condition has passed: zero on the next edge
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("clr after freed err", 32'(ptr_err), 0);

        // Mid-transfer reset discards in-flight synchronizer contents
        rd_ptr_gray = 5'b11111;
        tick(1);
        #2;
        wr_rstn = 1'b0;
        #1;
        check_all_zero("midreset");
        tick(1);
        check("midreset held gray_sync", 32'(rd_ptr_gray_sync), 0);
        wr_rstn = 1'b1;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/rptr_sync_wlevel.md
RPTR_SYNC_WLEVEL -- requirements
Module: rptr_sync_wlevel

Interface
REQ-001 Parameter ADDR_SIZE, default 4, FIFO address width; DEPTH = 2^ADDR_SIZE; pointers are ADDR_SIZE+1 bits.
REQ-002 Parameter SYNC_STAGES, default 2, number of synchronizer flops (legal 2..4).
REQ-003 Parameter AFULL_THRESH, default 12, level at which almost_full asserts (legal 1..DEPTH).
REQ-004 Parameter AFULL_HYST, default 2, hysteresis depth (legal 0..AFULL_THRESH-1).
REQ-005 wr_clk  input  1  write-domain clock.
REQ-006 wr_rstn  input  1  reset, asynchronous, active-low.
REQ-007 rd_ptr_gray  input  ADDR_SIZE+1  read pointer, Gray-coded, driven from the read clock domain (asynchronous to wr_clk).
REQ-008 wptr_bin  input  ADDR_SIZE+1  current binary write pointer, wr_clk domain.
REQ-009 err_clr  input  1  synchronous clear of ptr_err.
REQ-010 rd_ptr_gray_sync  output  ADDR_SIZE+1  last synchronizer stage, for the full-flag comparator.
REQ-011 rd_ptr_bin_sync  output  ADDR_SIZE+1  registered binary form of rd_ptr_gray_sync.
REQ-012 wr_level  output  ADDR_SIZE+1  registered FIFO occupancy seen from the write side, 0..DEPTH.
REQ-013 words_freed  output  ADDR_SIZE+1  registered count of entries the reader released since the previous cycle.
REQ-014 almost_full  output  1  registered watermark flag with hysteresis.
REQ-015 ptr_err  output  1  sticky pointer-consistency error.

Function
REQ-016 The synchronizer shall be a chain of SYNC_STAGES flops clocked by wr_clk with no logic between stages; rd_ptr_gray_sync shall be the last stage.
REQ-017 rd_ptr_bin_sync shall register the Gray-to-binary conversion of rd_ptr_gray_sync (bit n = XOR of Gray bits n..MSB), one cycle after rd_ptr_gray_sync.
REQ-018 level_next = (wptr_bin - rd_ptr_bin_sync) modulo 2^(ADDR_SIZE+1); wr_level shall register level_next every cycle.
REQ-019 Latency: a stable rd_ptr_gray change shall reach rd_ptr_gray_sync after SYNC_STAGES edges, rd_ptr_bin_sync after SYNC_STAGES+1, and wr_level after SYNC_STAGES+2; a wptr_bin change shall reach wr_level after 1 edge.
REQ-020 words_freed shall register (rd_ptr_bin_sync_next - rd_ptr_bin_sync) modulo 2^(ADDR_SIZE+1), where rd_ptr_bin_sync_next is the value being loaded into rd_ptr_bin_sync; it is 0 when the read pointer is static and may exceed 1 when the read clock is faster.
REQ-021 almost_full shall be a two-state machine: CLEAR->SET when level_next >= AFULL_THRESH; SET->CLEAR when level_next < AFULL_THRESH - AFULL_HYST; otherwise hold. It updates on the same edge as wr_level.
REQ-022 Wrap-around: the pointer MSB difference shall be handled by the modulo subtraction only; level_next = DEPTH (e.g. wptr 2, rptr 18 at ADDR_SIZE 4) is legal full.
REQ-023 ptr_err shall set when level_next > DEPTH or words_freed_next > DEPTH, and shall hold until err_clr or reset.
REQ-024 Set and err_clr in the same cycle: set shall win and ptr_err stays 1.
REQ-025 The block shall not feed back to or stall the write pointer; wfull generation remains outside this block.

Reset
REQ-026 On wr_rstn low, all synchronizer stages, rd_ptr_bin_sync, wr_level, words_freed, almost_full (CLEAR) and ptr_err shall go to 0 immediately, independent of wr_clk.
REQ-027 After wr_rstn deasserts, the first wr_clk edge shall resume normal operation; reset asserted mid-transfer shall discard in-flight synchronizer contents.

Verification
REQ-028 Reset: drive rd_ptr_gray=5'b10101, wptr_bin=7, assert wr_rstn low -> all outputs 0 without a clock edge.
REQ-029 Latency/almost_full: rd_ptr_gray=0, step wptr_bin 0..12 one per cycle -> wr_level tracks with 1-cycle lag; almost_full rises on the edge wr_level becomes 12.
REQ-030 Hysteresis: from wptr_bin=12, almost_full=1, step rd_ptr_gray through Gray codes of 1,2,3 -> wr_level 11,10 keep almost_full=1; wr_level 9 clears it, SYNC_STAGES+2 edges after rd_ptr_gray=5'b00010.
REQ-031 Fast reader: rd_ptr_gray jumps from Gray(4) to Gray(7) between two wr_clk edges -> words_freed=3 for one cycle, then 0.
REQ-032 Wrap: wptr_bin=2, rd_ptr_bin_sync=18 -> wr_level=16, ptr_err=0; wptr_bin=3 -> wr_level=17, ptr_err=1.
REQ-033 Sticky error: with ptr_err=1 and the error condition still present, pulse err_clr -> ptr_err stays 1; remove the condition, pulse err_clr -> ptr_err=0 next edge.
